// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the programmable interval timer:
//   - state_e        : controller state (IDLE, RUN)
//   - MODE_ONESHOT   : mode value for a single expiry then return to IDLE
//   - MODE_PERIODIC  : mode value for repeating expiry with reload at wrap
//   - DEFAULT_PERIOD : reset value of the latched period (legacy 2,000,000-cycle
//                      interval, i.e. terminal count 1999999)
// -----------------------------------------------------------------------------
package timer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   localparam int unsigned DEFAULT_PERIOD = 32'd1999999;

endpackage : timer_pkg

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the enable qualifier: counts enabled cycles 0..prescale and emits a
// tick on the enabled cycle that wraps the counter, giving one tick per
// prescale+1 enabled cycles. prescale is sampled live; prescale = 0 passes
// enable straight through. Only built when TIMER_PRESCALE_EN is defined.
//
// Ports:
//   clk      in  clock
//   reset_n  in  synchronous active-low reset
//   clear    in  restart the division (start/stop of the timer)
//   enable   in  cycle qualifier
//   prescale in  divide-by minus one
//   tick     out divided tick (combinational from register + enable)
// -----------------------------------------------------------------------------
`ifdef TIMER_PRESCALE_EN
module tick_prescaler #(
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt_q;
   logic [PRESCALE_W-1:0] cnt_d;
   logic                  wrap_s;

   // ">=" so a live reduction of prescale below the current count still wraps
   // promptly instead of running round the full counter range.
   assign wrap_s = (cnt_q >= prescale);
   assign tick   = enable & wrap_s;

   // Prescale counter next-state.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         if (wrap_s) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + PRESCALE_W'(1'b1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Prescale counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : tick_prescaler
`endif

// File: rtl/prog_timer.sv
// -----------------------------------------------------------------------------
// prog_timer
// Programmable interval timer with runtime-loadable period, one-shot or
// periodic mode and explicit start/stop. Expiry occurs after period+1 ticks.
//
// Optional feature macro: TIMER_PRESCALE_EN
//   defined   : tick comes from tick_prescaler (one tick per prescale+1
//               enabled cycles)
//   undefined : tick = enable; the prescale port is ignored
//
// Ports:
//   clk      in  clock
//   reset_n  in  synchronous active-low reset
//   start    in  latch period/mode and (re)start counting
//   stop     in  abort the run and return to IDLE (highest priority)
//   enable   in  tick qualifier; low pauses the count
//   mode     in  0 = one-shot, 1 = periodic (latched at start)
//   period   in  terminal count
//   clr      in  clear the sticky expired flag
//   prescale in  tick divider (prescaler builds only)
//   busy     out high while in RUN
//   done     out one-cycle pulse on expiry
//   expired  out sticky expiry flag
//   count    out current count
// -----------------------------------------------------------------------------
module prog_timer
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH        = 21,
   parameter int unsigned RESET_PERIOD = DEFAULT_PERIOD,
   parameter int unsigned PRESCALE_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  enable,
   input  logic                  mode,
   input  logic [WIDTH-1:0]      period,
   input  logic                  clr,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  busy,
   output logic                  done,
   output logic                  expired,
   output logic [WIDTH-1:0]      count
);

   state_e           state_q,   state_d;
   logic [WIDTH-1:0] count_q,   count_d;
   logic [WIDTH-1:0] period_q,  period_d;
   logic             mode_q,    mode_d;
   logic             done_q,    done_d;
   logic             expired_q, expired_d;
   logic             busy_q,    busy_d;
   logic             tick_s;
   logic             terminal_s;

`ifdef TIMER_PRESCALE_EN
   tick_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (start | stop),
      .enable   (enable),
      .prescale (prescale),
      .tick     (tick_s)
   );
`else
   logic unused_prescale_s;
   assign unused_prescale_s = ^prescale;
   assign tick_s            = enable;
`endif

   // count never passes period_q, so equality is the only terminal test needed.
   assign terminal_s = (count_q == period_q);

   // Controller next-state and registered-output values.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      period_d  = period_q;
      mode_d    = mode_q;
      done_d    = 1'b0;
      // clr first so that a coincident expiry below overrides it.
      expired_d = clr ? 1'b0 : expired_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               period_d  = period;
               mode_d    = mode;
               count_d   = '0;
               expired_d = 1'b0;
               state_d   = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               count_d = '0;
            end else if (start) begin
               period_d  = period;
               mode_d    = mode;
               count_d   = '0;
               expired_d = 1'b0;
            end else if (tick_s && terminal_s) begin
               done_d    = 1'b1;
               expired_d = 1'b1;
               count_d   = '0;
               if (mode_q == MODE_PERIODIC) begin
                  // Retune only at the wrap boundary.
                  period_d = period;
               end else begin
                  state_d = IDLE;
               end
            end else if (tick_s) begin
               count_d = count_q + WIDTH'(1'b1);
            end else begin
               count_d = count_q;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
      busy_d = (state_d == RUN);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         period_q  <= WIDTH'(RESET_PERIOD);
         mode_q    <= MODE_ONESHOT;
         done_q    <= 1'b0;
         expired_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         period_q  <= period_d;
         mode_q    <= mode_d;
         done_q    <= done_d;
         expired_q <= expired_d;
         busy_q    <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign expired = expired_q;
   assign count   = count_q;

endmodule : prog_timer

// File: tb/tb_prog_timer.sv
// -----------------------------------------------------------------------------
// tb_prog_timer
// Self-checking bench for prog_timer: a vector table, hand-written corner
// sequences and a randomized phase compared against a tick-counting model.
// A second 3-bit instance covers the all-ones period.
// -----------------------------------------------------------------------------
module tb_prog_timer;

   localparam int W  = 21;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          enable = 1'b0;
   logic          mode = 1'b0;
   logic          clr = 1'b0;
   logic [W-1:0]  period = '0;
   logic [PW-1:0] prescale = '0;
   logic          busy, done, expired;
   logic [W-1:0]  count;

   logic [2:0]    period3 = 3'd7;
   logic          busy3, done3, expired3;
   logic [2:0]    count3;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   prog_timer #(.WIDTH(W), .RESET_PERIOD(1999999), .PRESCALE_W(PW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .enable(enable),
      .mode(mode), .period(period), .clr(clr), .prescale(prescale),
      .busy(busy), .done(done), .expired(expired), .count(count)
   );

   prog_timer #(.WIDTH(3), .RESET_PERIOD(7), .PRESCALE_W(PW)) dut3 (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .enable(enable),
      .mode(mode), .period(period3), .clr(clr), .prescale(prescale),
      .busy(busy3), .done(done3), .expired(expired3), .count(count3)
   );

   // Reference model: tracks how many ticks have been seen since the run
   // started (or last wrapped); expiry is the (period+1)th tick.
   bit     m_run, m_mode, m_done, m_exp;
   longint m_per, m_seen;
   int     m_pc;

   task automatic model_step();
      bit tk;
      if (!reset_n) begin
         m_run = 0; m_mode = 0; m_done = 0; m_exp = 0;
         m_per = 1999999; m_seen = 0; m_pc = 0;
      end else begin
`ifdef TIMER_PRESCALE_EN
         tk = 0;
         if (start || stop) m_pc = 0;
         else if (enable) begin
            if (m_pc >= int'(prescale)) begin tk = 1; m_pc = 0; end
            else m_pc = m_pc + 1;
         end
`else
         tk = enable;
`endif
         m_done = 0;
         if (clr) m_exp = 0;
         if (!m_run) begin
            if (start) begin
               m_per = longint'(period); m_mode = mode; m_seen = 0; m_exp = 0; m_run = 1;
            end
         end else if (stop) begin
            m_run = 0; m_seen = 0;
         end else if (start) begin
            m_per = longint'(period); m_mode = mode; m_seen = 0; m_exp = 0;
         end else if (tk) begin
            if (m_seen + 1 == m_per + 1) begin
               m_done = 1; m_exp = 1; m_seen = 0;
               if (m_mode) m_per = longint'(period);
               else m_run = 0;
            end else begin
               m_seen = m_seen + 1;
            end
         end
      end
   endtask

   // Advance one clock edge; outputs are sampled 1 time unit after it.
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Step with inputs held until done rises; n = edges taken, -1 on timeout.
   task automatic wait_done(input int limit, output int n);
      int k;
      n = -1;
      k = 0;
      while (n < 0 && k < limit) begin
         step();
         k = k + 1;
         if (done) n = k;
      end
   endtask

   typedef struct {
      bit rst_n, st, sp, en, md, cl;
      int per;
      bit e_done, e_exp, e_busy;
      int e_cnt;
   } vec_t;

   vec_t tv[27];

   initial begin
      int n;
      int first;
      logic [W-1:0] prev;

      tv[0]  = '{0,0,0,0,0,0, 0, 0,0,0,0};
      tv[1]  = '{1,1,0,1,0,0, 4, 0,0,1,0};
      tv[2]  = '{1,0,0,1,0,0, 4, 0,0,1,1};
      tv[3]  = '{1,0,0,1,0,0, 4, 0,0,1,2};
      tv[4]  = '{1,0,0,1,0,0, 4, 0,0,1,3};
      tv[5]  = '{1,0,0,1,0,0, 4, 0,0,1,4};
      tv[6]  = '{1,0,0,1,0,0, 4, 1,1,0,0};
      tv[7]  = '{1,0,0,1,0,0, 4, 0,1,0,0};
      tv[8]  = '{1,0,0,1,0,1, 4, 0,0,0,0};
      tv[9]  = '{1,1,0,1,0,0, 1, 0,0,1,0};
      tv[10] = '{1,0,0,1,0,0, 1, 0,0,1,1};
      tv[11] = '{1,0,1,1,0,0, 1, 0,0,0,0};
      tv[12] = '{1,1,0,0,0,0, 2, 0,0,1,0};
      tv[13] = '{1,0,0,0,0,0, 2, 0,0,1,0};
      tv[14] = '{1,0,0,1,0,0, 2, 0,0,1,1};
      tv[15] = '{1,0,0,0,0,0, 2, 0,0,1,1};
      tv[16] = '{1,0,0,1,0,0, 2, 0,0,1,2};
      tv[17] = '{1,0,0,1,0,0, 2, 1,1,0,0};
      tv[18] = '{1,1,0,1,1,0, 0, 0,0,1,0};
      tv[19] = '{1,0,0,1,1,0, 0, 1,1,1,0};
      tv[20] = '{1,0,0,1,1,0, 0, 1,1,1,0};
      tv[21] = '{1,0,1,1,1,1, 0, 0,0,0,0};
      tv[22] = '{1,1,0,1,0,0,10, 0,0,1,0};
      tv[23] = '{1,0,0,1,0,0,10, 0,0,1,1};
      tv[24] = '{1,0,0,1,0,0,10, 0,0,1,2};
      tv[25] = '{1,0,0,1,0,0,10, 0,0,1,3};
      tv[26] = '{0,0,0,1,0,0,10, 0,0,0,0};

      #2;
      for (int i = 0; i < 27; i++) begin
         reset_n = tv[i].rst_n; start = tv[i].st; stop = tv[i].sp;
         enable = tv[i].en; mode = tv[i].md; clr = tv[i].cl;
         period = W'(tv[i].per); prescale = '0;
         step();
         chk($sformatf("vec%0d.done", i),    longint'(done),    longint'(tv[i].e_done));
         chk($sformatf("vec%0d.expired", i), longint'(expired), longint'(tv[i].e_exp));
         chk($sformatf("vec%0d.busy", i),    longint'(busy),    longint'(tv[i].e_busy));
         chk($sformatf("vec%0d.count", i),   longint'(count),   longint'(tv[i].e_cnt));
      end
      reset_n = 1'b1; start = 0; stop = 0; clr = 0;

      // Periodic, period 2: spacing 3 for ten periods, then retune to 5.
      mode = 1; period = W'(2); enable = 1; start = 1; step(); start = 0;
      for (int p = 0; p < 10; p++) begin
         wait_done(10, n);
         chk($sformatf("periodic_gap%0d", p), n, 3);
      end
      period = W'(5);
      step();
      wait_done(10, n);
      chk("retune_old_period", n, 2);
      wait_done(10, n);
      chk("retune_new_gap", n, 6);
      wait_done(10, n);
      chk("retune_new_gap2", n, 6);
      stop = 1; step(); stop = 0;
      chk("stop_busy", longint'(busy), 0);

      // Periodic, period 9, enable alternating: done on edge 20, count frozen.
      mode = 1; period = W'(9); enable = 0; start = 1; step(); start = 0;
      first = -1;
      for (int k = 1; k <= 22; k++) begin
         enable = (k % 2 == 0);
         prev = count;
         step();
         if (!enable) chk($sformatf("pause_hold%0d", k), longint'(count), longint'(prev));
         if (done && first < 0) first = k;
      end
      chk("toggle_enable_latency", first, 20);
      stop = 1; step(); stop = 0; enable = 1;

      // clr coincident with expiry: flag stays; clr alone clears.
      mode = 0; period = W'(0); start = 1; step(); start = 0;
      clr = 1; step();
      chk("clr_coincident_done", longint'(done), 1);
      chk("clr_coincident_expired", longint'(expired), 1);
      step();
      chk("clr_alone_expired", longint'(expired), 0);
      clr = 0;

      // Restart while running at count 7.
      mode = 0; period = W'(20); start = 1; step(); start = 0;
      for (int k = 0; k < 7; k++) step();
      chk("pre_restart_count", longint'(count), 7);
      start = 1; step(); start = 0;
      chk("restart_count", longint'(count), 0);
      chk("restart_done", longint'(done), 0);
      chk("restart_busy", longint'(busy), 1);
      stop = 1; step(); stop = 0;

      // Prescale latency, period 1.
      prescale = PW'(3); mode = 0; period = W'(1); start = 1; step(); start = 0;
      wait_done(30, n);
`ifdef TIMER_PRESCALE_EN
      chk("prescale_latency", n, 8);
`else
      chk("prescale_latency", n, 2);
`endif
      prescale = '0;

      // All-ones period on the 3-bit instance: expiry after 8 ticks.
      mode = 0; period = W'(0); start = 1; step(); start = 0;
      n = -1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (done3 && n < 0) n = k;
      end
      chk("allones_latency", n, 8);
      chk("allones_idle", longint'(busy3), 0);
      chk("allones_expired", longint'(expired3), 1);

      // Randomized phase against the model.
      reset_n = 0; step(); reset_n = 1;
      for (int c = 0; c < 3000; c++) begin
         reset_n  = ($urandom % 500) != 0;
         start    = ($urandom % 16) == 0;
         stop     = ($urandom % 40) == 0;
         enable   = ($urandom % 4) != 0;
         mode     = $urandom % 2;
         clr      = ($urandom % 16) == 0;
         if (($urandom % 8) == 0) period = W'($urandom % 8);
         if (($urandom % 64) == 0) prescale = PW'($urandom % 3);
         step();
         chk("rand.done",    longint'(done),    longint'(m_done));
         chk("rand.expired", longint'(expired), longint'(m_exp));
         chk("rand.busy",    longint'(busy),    longint'(m_run));
         chk("rand.count",   longint'(count),   m_seen);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_prog_timer
